dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of data_memory (32-bit words, 15-bit word address, 4-bit byte write enable, registered 1-cycle read).
- Port 0 is the CPU load/store unit; port 1 is the UART program/debug loader.
- Converts byte-addressed, sized requests into word address, byte enables and lane-replicated write data.
- Extracts and extends load data, flags misaligned accesses, and returns a per-port response.

Parameters:
- ADDR_W, 17, byte-address width (128 KiB space); word address = addr[ADDR_W-1:2].
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; one-hot or zero.
- req_we  in  2  per-port 1 = store, 0 = load.
- req_size  in  2x2  per-port access size {p1,p0}: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  2  per-port 1 = zero-extend load, 0 = sign-extend.
- req_addr  in  2xADDR_W  per-port byte address.
- req_wdata  in  2x32  per-port store data, right-aligned.
- rsp_valid  out  2  per-port one-cycle response pulse.
- rsp_rdata  out  32  load result, shared; valid with rsp_valid.
- rsp_err  out  1  misaligned/illegal flag, shared; valid with rsp_valid.
- mem_we  out  4  to data_memory we.
- mem_r_addr  out  15  to data_memory r_addr.
- mem_w_addr  out  15  to data_memory w_addr.
- mem_w_data  out  32  to data_memory w_data.
- mem_r_data  in  32  from data_memory r_data.

Behaviour:
- FSM states: IDLE -> ISSUE -> RESP -> IDLE, unconditional after IDLE.
  - Accepts only in IDLE; throughput is one access per 3 cycles.
- Reset:
  - While rst is high, every output is 0.
  - Async entry to IDLE; RR pointer = port 0; command register cleared.
- IDLE, arbitration:
  - Combinational req_ready for exactly one valid port.
  - Both ports valid: RR_EN=1 grants the port indicated by the pointer; RR_EN=0 grants port 0.
  - Pointer moves to the other port after each grant.
  - Single valid port is granted regardless of the pointer.
  - On the accepting edge, latch port id, we, size, unsigned, addr and wdata; go to ISSUE.
- Alignment check at accept:
  - err if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
- ISSUE (T+1):
  - mem_r_addr = mem_w_addr = latched addr[16:2].
  - Store without err: mem_we set per size.
    - byte: 1<<addr[1:0], mem_w_data = {4{wdata[7:0]}}.
    - half: addr[1]?1100:0011, mem_w_data = {2{wdata[15:0]}}.
    - word: 1111, mem_w_data = wdata.
  - Load or err: mem_we = 0.
  - mem_we is 0 in every state other than ISSUE.
- RESP (T+2):
  - rsp_valid[id] = 1 for exactly one cycle.
  - rsp_err = latched err.
  - Load without err: rsp_rdata is mem_r_data shifted right 8*addr[1:0], then sign- or zero-extended from 8 or 16 bits; word passes through.
  - Store or err: rsp_rdata = 0.
  - No response backpressure; the requester must take the response.
- Latency: accept at cycle T, rsp_valid at T+2, for loads and stores alike.
- mem_r_addr, mem_w_addr and mem_w_data hold their last ISSUE values in IDLE and RESP.
- req_valid dropped before grant: no effect; a requester may not withdraw after acceptance.
- Reset mid-operation:
  - Reset in ISSUE before the edge suppresses the write, since mem_we is forced 0.
  - Pending response is discarded; no rsp_valid is issued.

Decomposition:
- define.vh holds:
  - size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - FSM encodings S_IDLE, S_ISSUE, S_RESP.
  - port ids P_CPU=0, P_LDR=1.
- One combinational sub-module, dmem_lane_align:
  - Store path: size + addr[1:0] + wdata -> we mask + replicated data.
  - Load path: size + addr[1:0] + unsigned + r_data -> extended result.
  - Error flag.
- Arbiter, FSM and command register stay in dmem_arbiter.

Test Plan:
- Port0 store word 0xDEADBEEF at 0x00100, then load word at 0x00100.
  - ISSUE: mem_we=1111, mem_w_addr=0x0040.
  - Load response: rsp_rdata=0xDEADBEEF at T+2.
- Port0 store byte 0x80 at 0x00103, then load byte signed at 0x00103 -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Store: mem_we=1000, mem_w_data=0x80808080.
- Both ports valid on consecutive accepts, RR_EN=1, reset pointer at 0.
  - Grants go port0, port1, port0.
  - rsp_valid pulses on bits 0, 1, 0 at 3-cycle spacing.
- Misaligned half store at 0x00101 and word load at 0x00102.
  - mem_we stays 0000.
  - rsp_err=1, rsp_rdata=0, latency still 2.
- Half store 0xA5A5 at 0x00006; assert rst during ISSUE.
  - mem_we=0 and memory unchanged.
  - No rsp_valid; outputs 0.
  - After release, FSM in IDLE and port0 granted first.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states,
// port ids and the latched command record.
package dmem_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_RESP  = 2'b10
    } state_t;

    // Everything about an accepted request except its address, whose width is a parameter.
    typedef struct packed {
        logic        id;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } cmd_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between sized byte-addressed accesses and 32-bit memory words.
// Purely combinational: store mask/data, load extraction/extension, alignment error.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] r_data,
    output logic [3:0]  we_mask,
    output logic [31:0] w_data,
    output logic [31:0] rdata,
    output logic        err
);

    logic [31:0] shifted;

    assign err     = is_misaligned(size, addr_lo);
    assign shifted = r_data >> {addr_lo, 3'b000};

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        we_mask = 4'b0000;
        w_data  = wdata;
        case (size)
            SZ_B: begin
                we_mask = 4'b0001 << addr_lo;
                w_data  = {4{wdata[7:0]}};
            end
            SZ_H: begin
                we_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                w_data  = {2{wdata[15:0]}};
            end
            SZ_W: we_mask = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        case (size)
            SZ_B:    rdata = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata = r_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and IDLE/ISSUE/RESP sequencer in front of a 32-bit data memory
// with a registered one-cycle read; one access completes every three cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][1:0]        req_size,
    input  logic [1:0]             req_unsigned,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [3:0]             mem_we,
    output logic [ADDR_W-3:0]      mem_r_addr,
    output logic [ADDR_W-3:0]      mem_w_addr,
    output logic [31:0]            mem_w_data,
    input  logic [31:0]            mem_r_data
);

    state_t              state;
    logic                rr_ptr;
    cmd_t                cmd;
    logic [ADDR_W-1:0]   cmd_addr;

    logic                gnt_any;
    logic                gnt_id;
    logic [3:0]          we_mask;
    logic [31:0]         w_data;
    logic [31:0]         ld_data;
    logic                err;

    always_comb begin
        gnt_any = |req_valid;
        case (req_valid)
            2'b10:   gnt_id = P_LDR;
            2'b11:   gnt_id = RR_EN ? rr_ptr : P_CPU;
            default: gnt_id = P_CPU;
        endcase
    end

    // Ready is combinational, so it must be masked by rst to keep every output low in reset.
    assign req_ready = (state == S_IDLE && !rst && gnt_any) ? (2'b01 << gnt_id) : 2'b00;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= P_CPU;
            cmd       <= '0;
            cmd_addr  <= '0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    if (gnt_any) begin
                        cmd.id    <= gnt_id;
                        cmd.we    <= req_we[gnt_id];
                        cmd.size  <= req_size[gnt_id];
                        cmd.uns   <= req_unsigned[gnt_id];
                        cmd.wdata <= req_wdata[gnt_id];
                        cmd_addr  <= req_addr[gnt_id];
                        rr_ptr    <= ~gnt_id;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_valid <= 2'b01 << cmd.id;
                    rsp_err   <= err;
                    state     <= S_RESP;
                end
                default: begin
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    dmem_lane_align u_align (
        .size    (cmd.size),
        .addr_lo (cmd_addr[1:0]),
        .uns     (cmd.uns),
        .wdata   (cmd.wdata),
        .r_data  (mem_r_data),
        .we_mask (we_mask),
        .w_data  (w_data),
        .rdata   (ld_data),
        .err     (err)
    );

    // Address and data come straight from the command register, so they hold until the next accept.
    assign mem_r_addr = cmd_addr[ADDR_W-1:2];
    assign mem_w_addr = cmd_addr[ADDR_W-1:2];
    assign mem_w_data = w_data;
    assign mem_we     = (state == S_ISSUE && cmd.we && !err) ? we_mask : 4'b0000;

    // Read data only exists during RESP, so the load result is steered combinationally.
    assign rsp_rdata  = (|rsp_valid && !cmd.we && !rsp_err) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered-read data memory.
module tb_dmem_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][1:0]   req_size;
    logic [1:0]        req_unsigned;
    logic [1:0][16:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [3:0]        mem_we;
    logic [14:0]       mem_r_addr;
    logic [14:0]       mem_w_addr;
    logic [31:0]       mem_w_data;
    logic [31:0]       mem_r_data;

    logic [31:0]       mem [0:32767];
    int                checks;
    int                failures;

    dmem_arbiter #(.ADDR_W(17), .RR_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_r_addr   (mem_r_addr),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_w_addr][8*b +: 8] <= mem_w_data[8*b +: 8];
        mem_r_data <= mem[mem_r_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic we, input logic [1:0] size,
                         input logic uns, input logic [16:0] addr, input logic [31:0] wdata);
        req_valid[p]    = 1'b1;
        req_we[p]       = we;
        req_size[p]     = size;
        req_unsigned[p] = uns;
        req_addr[p]     = addr;
        req_wdata[p]    = wdata;
    endtask

    task automatic clear_req();
        req_valid    = 2'b00;
        req_we       = 2'b00;
        req_size     = '0;
        req_unsigned = 2'b00;
        req_addr     = '0;
        req_wdata    = '0;
    endtask

    // Single-port transaction: check ready, ISSUE outputs, then the RESP pulse.
    task automatic run_one(input string name, input int p, input logic we, input logic [1:0] size,
                           input logic uns, input logic [16:0] addr, input logic [31:0] wdata,
                           input logic [3:0] exp_we, input logic [31:0] exp_wd,
                           input logic exp_err, input logic [31:0] exp_rd);
        logic [1:0] exp_v;
        exp_v = (p == 0) ? 2'b01 : 2'b10;
        drive(p, we, size, uns, addr, wdata);
        #1;
        checks++;
        if (req_ready !== exp_v) begin
            failures++;
            $display("FAIL %s ready got=%b exp=%b", name, req_ready, exp_v);
        end
        step();
        clear_req();
        #1;
        checks++;
        if (mem_we !== exp_we || mem_w_addr !== addr[16:2] || mem_r_addr !== addr[16:2]) begin
            failures++;
            $display("FAIL %s issue we=%b waddr=%h raddr=%h exp we=%b addr=%h",
                     name, mem_we, mem_w_addr, mem_r_addr, exp_we, addr[16:2]);
        end
        if (exp_we != 4'b0000) begin
            checks++;
            if (mem_w_data !== exp_wd) begin
                failures++;
                $display("FAIL %s wdata got=%h exp=%h", name, mem_w_data, exp_wd);
            end
        end
        checks++;
        if (rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL %s early_rsp got=%b exp=00", name, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== exp_v || rsp_err !== exp_err || rsp_rdata !== exp_rd || mem_we !== 4'b0000) begin
            failures++;
            $display("FAIL %s resp valid=%b err=%b rdata=%h we=%b exp valid=%b err=%b rdata=%h we=0000",
                     name, rsp_valid, rsp_err, rsp_rdata, mem_we, exp_v, exp_err, exp_rd);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00 || mem_w_addr !== addr[16:2]) begin
            failures++;
            $display("FAIL %s idle valid=%b waddr=%h exp valid=00 waddr=%h",
                     name, rsp_valid, mem_w_addr, addr[16:2]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_req();
        req_valid = 2'b01;
        step();
        step();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 9'h0 ||
            {rsp_rdata, mem_r_addr, mem_w_addr, mem_w_data} !== 94'h0) begin
            failures++;
            $display("FAIL reset ready=%b valid=%b err=%b we=%b rdata=%h raddr=%h waddr=%h wdata=%h exp all zero",
                     req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_r_addr, mem_w_addr, mem_w_data);
        end
        clear_req();
        rst = 1'b0;
        step();
    endtask

    task automatic test_word();
        run_one("st_word", 0, 1'b1, 2'b10, 1'b0, 17'h00100, 32'hDEADBEEF,
                4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
        run_one("ld_word", 0, 1'b0, 2'b10, 1'b0, 17'h00100, 32'h0,
                4'b0000, 32'h0, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_byte();
        run_one("st_byte", 0, 1'b1, 2'b00, 1'b0, 17'h00103, 32'h00000080,
                4'b1000, 32'h80808080, 1'b0, 32'h0);
        run_one("ld_byte_s", 0, 1'b0, 2'b00, 1'b0, 17'h00103, 32'h0,
                4'b0000, 32'h0, 1'b0, 32'hFFFFFF80);
        run_one("ld_byte_u", 0, 1'b0, 2'b00, 1'b1, 17'h00103, 32'h0,
                4'b0000, 32'h0, 1'b0, 32'h00000080);
        run_one("ld_half_s", 0, 1'b0, 2'b01, 1'b0, 17'h00102, 32'h0,
                4'b0000, 32'h0, 1'b0, 32'hFFFF80AD);
        run_one("st_half_lo", 1, 1'b1, 2'b01, 1'b0, 17'h00200, 32'h00001234,
                4'b0011, 32'h12341234, 1'b0, 32'h0);
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_v [3];
        logic [31:0] exp_d [3];
        exp_v = '{2'b01, 2'b10, 2'b01};
        exp_d = '{32'h000000EF, 32'h80ADBEEF, 32'h000000EF};
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 1'b0, 2'b00, 1'b1, 17'h00100, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 17'h00100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== exp_v[i]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_v[i]);
            end
            step();
            checks++;
            if (req_ready !== 2'b00) begin
                failures++;
                $display("FAIL rr_busy%0d ready got=%b exp=00", i, req_ready);
            end
            step();
            checks++;
            if (rsp_valid !== exp_v[i] || rsp_rdata !== exp_d[i]) begin
                failures++;
                $display("FAIL rr_rsp%0d valid=%b rdata=%h exp valid=%b rdata=%h",
                         i, rsp_valid, rsp_rdata, exp_v[i], exp_d[i]);
            end
            step();
        end
        clear_req();
        step();
    endtask

    task automatic test_misaligned();
        run_one("mis_half_st", 0, 1'b1, 2'b01, 1'b0, 17'h00101, 32'h0000FFFF,
                4'b0000, 32'h0, 1'b1, 32'h0);
        run_one("mis_word_ld", 1, 1'b0, 2'b10, 1'b0, 17'h00102, 32'h0,
                4'b0000, 32'h0, 1'b1, 32'h0);
        run_one("illegal_size", 0, 1'b0, 2'b11, 1'b0, 17'h00100, 32'h0,
                4'b0000, 32'h0, 1'b1, 32'h0);
        checks++;
        if (mem[17'h00100 >> 2] !== 32'h80ADBEEF) begin
            failures++;
            $display("FAIL mis_mem_intact got=%h exp=80ADBEEF", mem[17'h00100 >> 2]);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 2'b01, 1'b0, 17'h00006, 32'h0000A5A5);
        step();
        clear_req();
        #1;
        checks++;
        if (mem_we !== 4'b1100 || mem_w_data !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL rstmid_issue we=%b wdata=%h exp we=1100 wdata=a5a5a5a5", mem_we, mem_w_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 4'b0000 || rsp_valid !== 2'b00 || mem_w_data !== 32'h0 || mem_w_addr !== 15'h0) begin
            failures++;
            $display("FAIL rstmid_outputs we=%b valid=%b wdata=%h waddr=%h exp all zero",
                     mem_we, rsp_valid, mem_w_data, mem_w_addr);
        end
        step();
        step();
        checks++;
        if (rsp_valid !== 2'b00 || mem[1] !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_no_effect valid=%b mem=%h exp valid=00 mem=00000000", rsp_valid, mem[1]);
        end
        rst = 1'b0;
        step();
        drive(0, 1'b0, 2'b10, 1'b0, 17'h00004, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 17'h00008, 32'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_first_grant got=%b exp=01", req_ready);
        end
        step();
        clear_req();
        step();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after valid=%b rdata=%h err=%b exp valid=01 rdata=0 err=0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_round_robin();
        test_misaligned();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
